// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   One pipeline stage register between two processor stages. It carries the
//   PC, the instruction word, an operand payload, a valid bit and a
//   register-write enable, plus two statistics counters.
//
//   Per-edge action, highest priority first:
//     flush : bubble. valid/instr/payload/reg_we clear, pc takes in_pc
//     stall : every field holds
//     load  : every field captures its in_* value
//
//   Ports
//     clk, reset            rising-edge clock, async active-high reset
//     in_valid/in_pc/in_instr/in_payload/in_reg_we   upstream slot
//     stall, flush          stage control
//     clr_cnt               synchronous clear of both counters
//     out_valid/out_pc/out_instr/out_payload        registered slot
//     out_reg_we            registered reg_we gated by registered valid
//     stall_cnt, bubble_cnt saturating statistics counters
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int          PAYLOAD_W = 96,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_reg_we,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 clr_cnt,
    output logic                 out_valid,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_reg_we,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic                 valid_q,      valid_d;
    logic [31:0]          pc_q,         pc_d;
    logic [31:0]          instr_q,      instr_d;
    logic [PAYLOAD_W-1:0] payload_q,    payload_d;
    logic                 reg_we_q,     reg_we_d;
    logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

    // A stall only counts when it actually holds the stage, i.e. not
    // overridden by a flush in the same cycle.
    logic stall_eff;
    assign stall_eff = stall & ~flush;

    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        payload_d = payload_q;
        reg_we_d  = reg_we_q;
        if (flush) begin
            // The bubble still carries the incoming PC so later stages can
            // tell where the squashed slot came from.
            valid_d   = 1'b0;
            pc_d      = in_pc;
            instr_d   = '0;
            payload_d = '0;
            reg_we_d  = 1'b0;
        end else if (!stall) begin
            valid_d   = in_valid;
            pc_d      = in_pc;
            instr_d   = in_instr;
            payload_d = in_payload;
            reg_we_d  = in_reg_we;
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            // Counters stick at all-ones instead of wrapping.
            if (stall_eff && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush && (bubble_cnt_q != {CNT_W{1'b1}}))
                bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            payload_q    <= '0;
            reg_we_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            payload_q    <= payload_d;
            reg_we_q     <= reg_we_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_instr   = instr_q;
    assign out_payload = payload_q;
    // A slot that is not valid never writes the register file, even when
    // the stored reg_we bit is set.
    assign out_reg_we  = reg_we_q & valid_q;
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Drives two instances of pipe_stage_reg from the same stimulus: one with
//   default parameters and one with 2-bit counters to reach saturation.
//   A behavioural model produces the expected output vector for every clock
//   edge; it is pushed into exp_q when the stimulus is driven and popped
//   when the outputs are sampled one edge later.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int PW    = 96;
    localparam int EXP_W = 1 + 1 + 32 + 32 + PW + 16 + 16 + 2 + 2;

    // clock / reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // DUT inputs
    logic          in_valid   = 1'b0;
    logic [31:0]   in_pc      = '0;
    logic [31:0]   in_instr   = '0;
    logic [PW-1:0] in_payload = '0;
    logic          in_reg_we  = 1'b0;
    logic          stall      = 1'b0;
    logic          flush      = 1'b0;
    logic          clr_cnt    = 1'b0;

    // DUT outputs (default instance)
    logic          out_valid, out_reg_we;
    logic [31:0]   out_pc, out_instr;
    logic [PW-1:0] out_payload;
    logic [15:0]   stall_cnt, bubble_cnt;

    // DUT outputs (2-bit counter instance)
    logic          s_valid, s_reg_we;
    logic [31:0]   s_pc, s_instr;
    logic [PW-1:0] s_payload;
    logic [1:0]    s_stall_cnt, s_bubble_cnt;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_payload(in_payload), .in_reg_we(in_reg_we),
        .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_payload(out_payload), .out_reg_we(out_reg_we),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_payload(in_payload), .in_reg_we(in_reg_we),
        .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
        .out_valid(s_valid), .out_pc(s_pc), .out_instr(s_instr),
        .out_payload(s_payload), .out_reg_we(s_reg_we),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
    );

    // scoreboard
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] got, expv;
    int total = 0;
    int bad   = 0;

    // behavioural model
    logic          m_valid, m_reg_we;
    logic [31:0]   m_pc, m_instr;
    logic [PW-1:0] m_payload;
    logic [15:0]   m_scnt, m_bcnt;
    logic [1:0]    m2_scnt, m2_bcnt;

    function automatic logic [EXP_W-1:0] model_vec();
        return {m_valid, m_valid & m_reg_we, m_pc, m_instr, m_payload,
                m_scnt, m_bcnt, m2_scnt, m2_bcnt};
    endfunction

    function automatic logic [EXP_W-1:0] dut_vec();
        return {out_valid, out_reg_we, out_pc, out_instr, out_payload,
                stall_cnt, bubble_cnt, s_stall_cnt, s_bubble_cnt};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_reg_we = 1'b0; m_pc = 32'h0000_3000;
        m_instr = '0; m_payload = '0;
        m_scnt = '0; m_bcnt = '0; m2_scnt = '0; m2_bcnt = '0;
    endtask

    // Drive one cycle of stimulus (called just after a rising edge), advance
    // the model, push the expectation and wait until #1 after the next edge.
    task automatic step(input logic v, input logic [31:0] pc,
                        input logic [31:0] instr, input logic [PW-1:0] pl,
                        input logic we, input logic st, input logic fl,
                        input logic clr);
        in_valid = v; in_pc = pc; in_instr = instr; in_payload = pl;
        in_reg_we = we; stall = st; flush = fl; clr_cnt = clr;
        if (fl) begin
            m_valid = 1'b0; m_pc = pc; m_instr = '0; m_payload = '0;
            m_reg_we = 1'b0;
        end else if (!st) begin
            m_valid = v; m_pc = pc; m_instr = instr; m_payload = pl;
            m_reg_we = we;
        end
        if (clr) begin
            m_scnt = '0; m_bcnt = '0; m2_scnt = '0; m2_bcnt = '0;
        end else begin
            if (st && !fl) begin
                if (m_scnt  != 16'hffff) m_scnt  = m_scnt + 1'b1;
                if (m2_scnt != 2'd3)     m2_scnt = m2_scnt + 1'b1;
            end
            if (fl) begin
                if (m_bcnt  != 16'hffff) m_bcnt  = m_bcnt + 1'b1;
                if (m2_bcnt != 2'd3)     m2_bcnt = m2_bcnt + 1'b1;
            end
        end
        exp_q.push_back(model_vec());
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = '0; in_instr = '0; in_payload = '0;
        in_reg_we = 1'b0; stall = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        // async assertion, checked before any clock edge
        #2 reset = 1'b1;
        model_reset();
        #1;
        got = dut_vec(); expv = model_vec(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL reset_async got=%h exp=%h", got, expv);
        end
        // activity while reset is held must be ignored
        in_valid = 1'b1; in_pc = 32'h1234; in_instr = 32'hdead_beef;
        in_reg_we = 1'b1; stall = 1'b1; flush = 1'b1; clr_cnt = 1'b0;
        @(posedge clk); #1;
        got = dut_vec(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL reset_held got=%h exp=%h", got, expv);
        end
        idle_inputs();
        reset = 1'b0;
        // load something, then a reset pulse fully between edges
        step(1'b1, 32'h0000_5550, 32'h1111_2222, 96'h5, 1'b1, 1'b0, 1'b0, 1'b0);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL reset_preload got=%h exp=%h", got, expv);
        end
        reset = 1'b1; #2 reset = 1'b0; #1;
        model_reset();
        total++;
        if (out_pc !== 32'h0000_3000 || out_instr !== 32'h0 || out_valid !== 1'b0 ||
            out_reg_we !== 1'b0 || out_payload !== '0 || stall_cnt !== 16'h0 ||
            bubble_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_pulse got pc=%h instr=%h valid=%b exp pc=00003000 instr=0 valid=0",
                            out_pc, out_instr, out_valid);
        end
    endtask

    task automatic test_load();
        step(1'b1, 32'h0000_3004, 32'h8C01_0004, 96'hA5A5_0001_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL load got=%h exp=%h", got, expv);
        end
        total++;
        if (out_pc !== 32'h0000_3004 || out_instr !== 32'h8C01_0004 || out_reg_we !== 1'b1 ||
            out_valid !== 1'b1) begin
            bad++; $display("FAIL load_const got pc=%h instr=%h we=%b exp pc=00003004 instr=8c010004 we=1",
                            out_pc, out_instr, out_reg_we);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step($urandom_range(1, 0), $urandom(), $urandom(), {3{$urandom()}},
                 1'b1, 1'b1, 1'b0, 1'b0);
            got = dut_vec(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL stall_%0d got=%h exp=%h", i, got, expv);
            end
        end
        total++;
        if (out_pc !== 32'h0000_3004 || out_instr !== 32'h8C01_0004 || stall_cnt !== 16'd3) begin
            bad++; $display("FAIL stall_const got pc=%h instr=%h scnt=%0d exp pc=00003004 instr=8c010004 scnt=3",
                            out_pc, out_instr, stall_cnt);
        end
    endtask

    task automatic test_stall_flush();
        step(1'b1, 32'h0000_3008, 32'hFFFF_0000, 96'h77, 1'b1, 1'b1, 1'b1, 1'b0);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL stall_flush got=%h exp=%h", got, expv);
        end
        total++;
        if (out_pc !== 32'h0000_3008 || out_instr !== 32'h0 || out_valid !== 1'b0 ||
            out_reg_we !== 1'b0 || bubble_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
            bad++; $display("FAIL stall_flush_const got pc=%h bcnt=%0d scnt=%0d exp pc=00003008 bcnt=1 scnt=3",
                            out_pc, bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_invalid_load();
        step(1'b0, 32'h0000_300C, 32'h2002_0007, 96'h9, 1'b1, 1'b0, 1'b0, 1'b0);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL invalid_load got=%h exp=%h", got, expv);
        end
        total++;
        if (out_reg_we !== 1'b0 || out_instr !== 32'h2002_0007) begin
            bad++; $display("FAIL invalid_load_const got we=%b instr=%h exp we=0 instr=20020007",
                            out_reg_we, out_instr);
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL sat_clear got=%h exp=%h", got, expv);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h4000 + i * 4, 32'hABCD_0000, '1, 1'b1, 1'b0, 1'b1, 1'b0);
            got = dut_vec(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL sat_flush_%0d got=%h exp=%h", i, got, expv);
            end
        end
        total++;
        if (s_bubble_cnt !== 2'd3 || bubble_cnt !== 16'd5) begin
            bad++; $display("FAIL sat_value got small=%0d big=%0d exp small=3 big=5",
                            s_bubble_cnt, bubble_cnt);
        end
        // clear wins over the increment of a simultaneous flush
        step(1'b1, 32'h5000, 32'h1, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv || s_bubble_cnt !== 2'd0) begin
            bad++; $display("FAIL sat_clr got=%h exp=%h", got, expv);
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1'b1, 32'h6000, 32'h6000_0001, 96'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL mid_preload got=%h exp=%h", got, expv);
        end
        // stall and flush pending; reset arrives before the edge
        in_valid = 1'b1; in_pc = 32'h7000; stall = 1'b1; flush = 1'b1;
        #3 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        got = dut_vec(); expv = model_vec(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL mid_abort got=%h exp=%h", got, expv);
        end
        reset = 1'b0;
        // first edge after release: stall alone holds reset contents
        step(1'b1, 32'h7004, 32'h7, 96'h7, 1'b1, 1'b1, 1'b0, 1'b0);
        got = dut_vec(); expv = exp_q.pop_front(); total++;
        if (got !== expv) begin
            bad++; $display("FAIL mid_first_edge got=%h exp=%h", got, expv);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(1, 0), $urandom(), $urandom(),
                 {$urandom(), $urandom(), $urandom()}, $urandom_range(1, 0),
                 ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) == 0),
                 ($urandom_range(40, 0) == 0));
            got = dut_vec(); expv = exp_q.pop_front(); total++;
            if (got !== expv) begin
                bad++; $display("FAIL random_%0d got=%h exp=%h", i, got, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_stall_flush();
        test_invalid_load();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 96, width of generic operand payload (e.g. rs value, rt value, immediate).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-003 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-004 SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-005 in_valid  input  1  upstream slot holds a real instruction.
REQ-006 in_pc  input  32  upstream PC.
REQ-007 in_instr  input  32  upstream instruction word.
REQ-008 in_payload  input  PAYLOAD_W  upstream operand bundle.
REQ-009 in_reg_we  input  1  upstream register-write enable.
REQ-010 stall  input  1  hold current contents.
REQ-011 flush  input  1  insert bubble.
REQ-012 clr_cnt  input  1  synchronous clear of both counters.
REQ-013 out_valid  output  1  stage holds a real instruction.
REQ-014 out_pc, out_instr  output  32 each  registered PC and instruction.
REQ-015 out_payload  output  PAYLOAD_W  registered operand bundle.
REQ-016 out_reg_we  output  1  registered write enable, gated by valid.
REQ-017 stall_cnt, bubble_cnt  output  CNT_W each  statistics counters.

Function
REQ-018 Each rising clk edge SHALL apply exactly one action, priority flush > stall > load.
REQ-019 Load (flush=0, stall=0): every field SHALL capture its in_* value; visible on outputs one cycle later (latency 1).
REQ-020 Stall (stall=1, flush=0): every field SHALL hold its value unchanged.
REQ-021 Flush (flush=1): valid, instr, reg_we and payload SHALL clear to 0; pc SHALL capture in_pc, so the bubble carries the incoming PC.
REQ-022 stall=1 and flush=1 in the same cycle SHALL behave as flush.
REQ-023 out_reg_we SHALL equal registered reg_we AND registered valid; no register write leaves a bubble.
REQ-024 Load with in_valid=0 SHALL store the fields as given, but out_reg_we SHALL still be 0.
REQ-025 stall_cnt SHALL increment by 1 on each edge where stall=1 and flush=0.
REQ-026 bubble_cnt SHALL increment by 1 on each edge where flush=1.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-028 clr_cnt=1 SHALL set both counters to 0 on that edge, overriding any increment; pipeline fields are unaffected.
REQ-029 All outputs SHALL come directly from flops; no combinational path from inputs to outputs except the valid gating of out_reg_we.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for clk, set out_pc=RESET_PC, out_instr=0, out_payload=0, out_valid=0, out_reg_we=0, stall_cnt=0, bubble_cnt=0.
REQ-031 While reset=1, stall, flush, load and counter activity SHALL be ignored.
REQ-032 On the first edge after reset deasserts, normal priority SHALL apply.
REQ-033 reset asserted mid-stall or mid-flush SHALL abort that action with no partial update.

Verification
REQ-034 Reset pulse between edges -> outputs immediately pc=0x3000, instr=0, valid=0, counters=0.
REQ-035 Load in_pc=0x3004, instr=0x8C010004, reg_we=1, valid=1 -> next cycle same values out, out_reg_we=1.
REQ-036 Three stall cycles after REQ-035 -> outputs frozen at 0x3004/0x8C010004, stall_cnt=3.
REQ-037 stall=1 and flush=1 with in_pc=0x3008 -> out_pc=0x3008, instr=0, valid=0, out_reg_we=0, bubble_cnt+1, stall_cnt unchanged.
REQ-038 CNT_W=2 with 5 consecutive flushes -> bubble_cnt=3 (saturated); then clr_cnt=1 with flush=1 -> bubble_cnt=0.
REQ-039 Load valid=0, reg_we=1 -> out_reg_we=0, out_instr equals input.
